fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of control_unit.
//  Owns the PC and issues one-outstanding-request fetches to instruction memory.
//  Holds the fetched word across decode stalls and kills wrong-path fetches on redirect.
//  Presents instr_d/pc_d to decode; invalid slots carry a NOP so decode is harmless.
// PARAMETERS
//  DATA_WIDTH  32     instruction/data word width
//  ADDR_WIDTH  32     PC / imem address width
//  RESET_PC    32'h0  first fetch address after reset
// PORTS
//  clk          in   1           clock, all state updates on rising edge
//  rst_n        in   1           reset, synchronous, active-low
//  stall        in   1           decode cannot accept; hold IF/ID contents
//  redirect_valid in 1           taken branch/jal/jalr from EX; flush and refetch
//  redirect_pc  in   ADDR_WIDTH  redirect target; bits [1:0] ignored (treated as 00)
//  imem_req     out  1           fetch request, one cycle per request
//  imem_addr    out  ADDR_WIDTH  fetch address, valid with imem_req
//  imem_rvalid  in   1           response valid (>=1 cycle after imem_req)
//  imem_rdata   in   DATA_WIDTH  fetched instruction, valid with imem_rvalid
//  instr_d      out  DATA_WIDTH  instruction to decode (NOP 32'h00000013 when !valid_d)
//  pc_d         out  ADDR_WIDTH  PC of instr_d
//  pc_plus4_d   out  ADDR_WIDTH  pc_d + 4, wraps modulo 2^ADDR_WIDTH
//  valid_d      out  1           instr_d is a real instruction
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc<=RESET_PC, state<=FETCH, hold_valid<=0, valid_d<=0, instr_d<=NOP,
//   pc_d<=0, pc_plus4_d<=4, imem_req=0 during reset cycle. Reset mid-request drops the response.
//  FSM states: FETCH, WAIT, DROP.
//   FETCH: if !hold_valid && !redirect_valid: imem_req=1, imem_addr=pc, -> WAIT. Else stay, req=0.
//   WAIT: on imem_rvalid: word goes to IF/ID if !stall, else into hold register (hold_valid<=1);
//    pc<=pc+4; -> FETCH. No rvalid: stay.
//   DROP: wrong-path response outstanding; on imem_rvalid discard data, -> FETCH.
//  Redirect (highest priority, any state): pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}; valid_d<=0,
//   instr_d<=NOP; hold_valid<=0; WAIT->DROP; WAIT with same-cycle rvalid -> FETCH (data discarded);
//   DROP stays DROP unless rvalid that cycle. Redirect overrides stall.
//  Stall (no redirect): IF/ID regs hold all values; a response arriving goes to hold register;
//   no new imem_req while hold_valid=1.
//  Stall release: hold_valid=1 -> hold moves into IF/ID same edge, hold_valid<=0.
//   Else if no response that cycle: valid_d<=0, instr_d<=NOP (bubble).
//  Latency: imem_req -> instr_d visible = imem latency + 1 edge. One request outstanding max;
//   peak throughput one instruction per (latency+1) cycles.
//  pc+4 arithmetic: ADDR_WIDTH-bit, wraps at top of address space without error.
//  imem_rvalid in FETCH state (no request outstanding): ignored.
// STRUCTURE
//  def.sv: `NOP_INSTR (32'h00000013), `FETCH_S/`WAIT_S/`DROP_S state encodings (2-bit).
//  Sub-module if_id_reg: instr/pc/pc_plus4/valid register with load, flush, hold; reset to NOP.
//  FSM, PC register and hold register stay in fetch_stage.
// TESTING
//  1 Reset, imem latency 1, linear code -> imem_addr 0,4,8,...; instr_d matches each word,
//    valid_d=1 every other cycle; pc_plus4_d=pc_d+4.
//  2 stall=1 for 3 cycles while response at pc=8 arrives -> instr_d/pc_d frozen, no imem_req
//    while hold_valid; on release pc_d=8 next edge, fetch of 12 issued.
//  3 redirect_pc=0x100 while WAIT (latency 3) -> wrong response discarded, valid_d=0 with NOP,
//    next imem_addr=0x100, pc_d=0x100 appears.
//  4 redirect_valid with stall=1 -> flush wins: valid_d=0, instr_d=32'h00000013, hold cleared.
//  5 redirect_pc=0x203 -> fetch at 0x200; pc=0xFFFFFFFC fetch -> next imem_addr 0x0.
//  6 rst_n=0 during WAIT, rvalid arrives after reset -> discarded; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_S = 2'd0,
    WAIT_S  = 2'd1,
    DROP_S  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold beats load; otherwise a NOP bubble is inserted.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  hold_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_o    <= DATA_WIDTH'(NOP_INSTR);
      pc_o       <= '0;
      pc_plus4_o <= ADDR_WIDTH'(4);
      valid_o    <= 1'b0;
    end else if (flush_i) begin
      instr_o <= DATA_WIDTH'(NOP_INSTR);
      valid_o <= 1'b0;
    end else if (hold_i) begin
      instr_o <= instr_o;
    end else if (load_i) begin
      instr_o    <= instr_i;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_i + ADDR_WIDTH'(4);
      valid_o    <= 1'b1;
    end else begin
      instr_o <= DATA_WIDTH'(NOP_INSTR);
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, buffers a word
// across decode stalls and discards wrong-path responses after a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = DATA_W,
  parameter int unsigned         ADDR_WIDTH = ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_d,
  output logic [ADDR_WIDTH-1:0] pc_d,
  output logic [ADDR_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  rsp_take;
  logic                  ifid_load;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic [ADDR_WIDTH-1:0] ifid_pc;

  // Target alignment forces the two low bits to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH_S;
      fetch_pc_q   <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= DATA_WIDTH'(NOP_INSTR);
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    imem_req     = 1'b0;
    rsp_take     = 1'b0;

    case (state_q)
      FETCH_S: begin
        if (!hold_valid_q && !redirect_valid) begin
          imem_req = 1'b1;
          state_d  = WAIT_S;
        end
      end
      WAIT_S: begin
        if (imem_rvalid) begin
          state_d = FETCH_S;
          if (!redirect_valid) begin
            rsp_take   = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          end
        end else if (redirect_valid) begin
          state_d = DROP_S;
        end
      end
      DROP_S: begin
        if (imem_rvalid) state_d = FETCH_S;
      end
      default: state_d = FETCH_S;
    endcase

    if (redirect_valid) fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // Hold register captures a response that decode cannot take; drains on release.
    if (redirect_valid) begin
      hold_valid_d = 1'b0;
    end else if (stall) begin
      if (rsp_take) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_rdata;
        hold_pc_d    = fetch_pc_q;
      end
    end else begin
      hold_valid_d = 1'b0;
    end

    if (!rst_n) imem_req = 1'b0;
  end

  assign imem_addr  = fetch_pc_q;
  assign ifid_load  = hold_valid_q || rsp_take;
  assign ifid_instr = hold_valid_q ? hold_instr_q : imem_rdata;
  assign ifid_pc    = hold_valid_q ? hold_pc_q : fetch_pc_q;

  fetch_stage_if_id_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_valid),
    .hold_i    (stall),
    .load_i    (ifid_load),
    .instr_i   (ifid_instr),
    .pc_i      (ifid_pc),
    .instr_o   (instr_d),
    .pc_o      (pc_d),
    .pc_plus4_o(pc_plus4_d),
    .valid_o   (valid_d)
  );

endmodule
